// File: rtl/aes_pkg.sv
// Shared AES datapath types and the ShiftRows byte permutation tables.
// Tables give, for each output byte j, the input byte index it takes.
package aes_pkg;

    typedef logic [7:0]       aes_byte_t;
    typedef logic [127:0]     aes_state_t;
    typedef logic [15:0][3:0] aes_perm_t;

    // Entry j is the source index of output byte j; entry 0 is the rightmost literal.
    localparam aes_perm_t SHIFTROW_FWD_SRC = {
        4'd15, 4'd10, 4'd5,  4'd0,
        4'd11, 4'd6,  4'd1,  4'd12,
        4'd7,  4'd2,  4'd13, 4'd8,
        4'd3,  4'd14, 4'd9,  4'd4
    };

    localparam aes_perm_t SHIFTROW_INV_SRC = {
        4'd15, 4'd2,  4'd5,  4'd8,
        4'd11, 4'd14, 4'd1,  4'd4,
        4'd7,  4'd10, 4'd13, 4'd0,
        4'd3,  4'd6,  4'd9,  4'd12
    };

    // Invert a source table: the output position that input byte idx lands in.
    function automatic logic [3:0] perm_dst(input aes_perm_t src, input logic [3:0] idx);
        logic [3:0] dst;
        dst = 4'd0;
        for (int j = 0; j < 16; j++) begin
            if (src[j] == idx) begin
                dst = 4'(j);
            end
        end
        return dst;
    endfunction

endpackage

// File: rtl/aes_shiftrow_ser.sv
// Byte-serial ShiftRows engine: bytes are scattered straight into their permuted
// slot of a ping-pong bank, and a completed bank is offered as one 128-bit word.
module aes_shiftrow_ser
    import aes_pkg::*;
#(
    parameter logic INV = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [7:0]   s_byte,
    input  logic         s_last,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [127:0] m_data,
    output logic         err
);

    localparam aes_perm_t SRC = INV ? SHIFTROW_INV_SRC : SHIFTROW_FWD_SRC;

    aes_state_t bank_q [2];
    aes_state_t bank_d [2];
    logic [1:0] full_q, full_d;
    logic       wr_bank_q, wr_bank_d;
    logic       rd_bank_q, rd_bank_d;
    logic [3:0] cnt_q, cnt_d;
    logic       err_q, err_d;

    logic       s_fire;
    logic       m_fire;
    logic       at_end;
    logic [3:0] dst;

    // Handshake: a transfer happens on a rising clk edge where valid && ready;
    // valid/data are held until that edge, ready never depends on valid.
    assign s_ready = !full_q[wr_bank_q];
    assign m_valid = full_q[rd_bank_q];
    assign m_data  = bank_q[rd_bank_q];
    assign err     = err_q;

    assign s_fire = s_valid && s_ready;
    assign m_fire = m_valid && m_ready;
    assign at_end = (cnt_q == 4'd15);
    assign dst    = perm_dst(SRC, cnt_q);

    always_comb begin
        bank_d    = bank_q;
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        cnt_d     = cnt_q;
        err_d     = 1'b0;

        if (m_fire) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = !rd_bank_q;
        end

        // A fill can only target an empty bank, so it never collides with the pop above.
        if (s_fire) begin
            bank_d[wr_bank_q][{dst, 3'b000} +: 8] = s_byte;
            if (at_end && s_last) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
                cnt_d             = 4'd0;
            end else if (at_end || s_last) begin
                err_d = 1'b1;
                cnt_d = 4'd0;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bank_q[0] <= '0;
            bank_q[1] <= '0;
            full_q    <= 2'b00;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            cnt_q     <= 4'd0;
            err_q     <= 1'b0;
        end else begin
            bank_q    <= bank_d;
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_aes_shiftrow_ser.sv
// Directed bench for aes_shiftrow_ser: forward and inverse instances, then a
// forward->inverse round trip through both with random gaps.
module tb_aes_shiftrow_ser;

    localparam int RT_N  = 1000;
    localparam int BOUND = 1000;

    localparam logic [127:0] EXP_FWD_BASE = 128'h0f0a05000b06010c07020d08030e0904;
    localparam logic [127:0] EXP_INV_BASE = 128'h0f0205080b0e0104070a0d000306090c;
    localparam logic [127:0] EXP_FWD_A    = 128'h1f1a15101b16111c17121d18131e1914;
    localparam logic [127:0] EXP_FWD_B    = 128'h2f2a25202b26212c27222d28232e2924;
    localparam logic [127:0] EXP_FWD_C    = 128'h3f3a35303b36313c37323d38333e3934;

    logic clk = 1'b0;
    logic reset;

    logic         fs_valid, fs_ready, fs_last, fm_valid, fm_ready, f_err;
    logic [7:0]   fs_byte;
    logic [127:0] fm_data;
    logic         is_valid, is_ready, is_last, im_valid, im_ready, i_err;
    logic [7:0]   is_byte;
    logic [127:0] im_data;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    bit abort   = 1'b0;

    logic [127:0] exp_q[$];
    logic [127:0] p_state, g_word, c_exp;
    int g_wait, c_wait;

    always #5 clk = ~clk;

    aes_shiftrow_ser #(.INV(1'b0)) dut_fwd (
        .clk(clk), .reset(reset),
        .s_valid(fs_valid), .s_ready(fs_ready), .s_byte(fs_byte), .s_last(fs_last),
        .m_valid(fm_valid), .m_ready(fm_ready), .m_data(fm_data), .err(f_err)
    );

    aes_shiftrow_ser #(.INV(1'b1)) dut_inv (
        .clk(clk), .reset(reset),
        .s_valid(is_valid), .s_ready(is_ready), .s_byte(is_byte), .s_last(is_last),
        .m_valid(im_valid), .m_ready(im_ready), .m_data(im_data), .err(i_err)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic expv);
        check(tag, {127'b0, obs}, {127'b0, expv});
    endtask

    // Called at a negedge; returns at the negedge after the byte was accepted.
    task automatic send_byte(input bit sel, input logic [7:0] b, input logic last);
        int waited = 0;
        if (sel) begin
            is_valid = 1'b1; is_byte = b; is_last = last;
        end else begin
            fs_valid = 1'b1; fs_byte = b; fs_last = last;
        end
        while (!(sel ? is_ready : fs_ready) && waited < BOUND) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= BOUND) begin
            check_bit("s_ready wait timeout", 1'b0, 1'b1);
            abort = 1'b1;
        end else begin
            @(negedge clk);
        end
        if (sel) is_valid = 1'b0;
        else     fs_valid = 1'b0;
    endtask

    task automatic send_block(input bit sel, input logic [7:0] base, input logic with_last);
        for (int k = 0; k < 16; k++) begin
            send_byte(sel, base + 8'(k), with_last && (k == 15));
        end
    endtask

    initial begin
        reset    = 1'b1;
        fs_valid = 1'b0; fs_byte = '0; fs_last = 1'b0; fm_ready = 1'b0;
        is_valid = 1'b0; is_byte = '0; is_last = 1'b0; im_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check_bit("reset s_ready", fs_ready, 1'b1);
        check_bit("reset m_valid", fm_valid, 1'b0);
        check("reset m_data", fm_data, 128'h0);
        check_bit("reset err", f_err, 1'b0);

        // Basic forward block, consumer always ready.
        fm_ready = 1'b1;
        for (int k = 0; k < 15; k++) send_byte(1'b0, 8'(k), 1'b0);
        check_bit("fwd m_valid before last", fm_valid, 1'b0);
        send_byte(1'b0, 8'd15, 1'b1);
        check_bit("fwd m_valid latency", fm_valid, 1'b1);
        check("fwd data", fm_data, EXP_FWD_BASE);
        check_bit("fwd err", f_err, 1'b0);
        @(negedge clk);
        check_bit("fwd m_valid after pop", fm_valid, 1'b0);

        // Inverse mapping instance.
        im_ready = 1'b1;
        send_block(1'b1, 8'h00, 1'b1);
        check_bit("inv m_valid", im_valid, 1'b1);
        check("inv data", im_data, EXP_INV_BASE);
        @(negedge clk);
        check_bit("inv m_valid after pop", im_valid, 1'b0);

        // Backpressure: two blocks fill, third stalls until a bank frees.
        fm_ready = 1'b0;
        send_block(1'b0, 8'h10, 1'b1);
        send_block(1'b0, 8'h20, 1'b1);
        check_bit("bp s_ready both full", fs_ready, 1'b0);
        check_bit("bp m_valid", fm_valid, 1'b1);
        check("bp first block", fm_data, EXP_FWD_A);
        fs_valid = 1'b1; fs_byte = 8'h30; fs_last = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_bit("bp s_ready held low", fs_ready, 1'b0);
            check("bp m_data stable", fm_data, EXP_FWD_A);
        end
        fm_ready = 1'b1;
        @(negedge clk);
        fm_ready = 1'b0;
        check_bit("bp m_valid second", fm_valid, 1'b1);
        check("bp second block", fm_data, EXP_FWD_B);
        check_bit("bp s_ready after pop", fs_ready, 1'b1);
        send_block(1'b0, 8'h30, 1'b1);
        check_bit("bp s_ready refilled", fs_ready, 1'b0);
        check("bp second stable", fm_data, EXP_FWD_B);
        fm_ready = 1'b1;
        @(negedge clk);
        check("bp third block", fm_data, EXP_FWD_C);
        @(negedge clk);
        check_bit("bp drained", fm_valid, 1'b0);

        // Framing: early s_last on the 5th byte.
        for (int k = 0; k < 5; k++) send_byte(1'b0, 8'h70 + 8'(k), k == 4);
        check_bit("early last err", f_err, 1'b1);
        check_bit("early last no m_valid", fm_valid, 1'b0);
        @(negedge clk);
        check_bit("early last err one cycle", f_err, 1'b0);
        send_block(1'b0, 8'h00, 1'b1);
        check("after early last data", fm_data, EXP_FWD_BASE);
        check_bit("after early last m_valid", fm_valid, 1'b1);
        @(negedge clk);

        // Framing: 16 bytes with no s_last.
        send_block(1'b0, 8'h40, 1'b0);
        check_bit("missing last err", f_err, 1'b1);
        check_bit("missing last no m_valid", fm_valid, 1'b0);
        @(negedge clk);
        check_bit("missing last err one cycle", f_err, 1'b0);
        check_bit("missing last dropped", fm_valid, 1'b0);

        // Reset mid-fill with one bank pending.
        fm_ready = 1'b0;
        send_block(1'b0, 8'h50, 1'b1);
        for (int k = 0; k < 7; k++) send_byte(1'b0, 8'h60 + 8'(k), 1'b0);
        check_bit("pre-reset m_valid", fm_valid, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_bit("mid reset m_valid", fm_valid, 1'b0);
        check_bit("mid reset s_ready", fs_ready, 1'b1);
        check("mid reset m_data", fm_data, 128'h0);
        check_bit("mid reset err", f_err, 1'b0);
        fm_ready = 1'b1;
        send_block(1'b0, 8'h00, 1'b1);
        check("post reset data", fm_data, EXP_FWD_BASE);
        check_bit("post reset err", f_err, 1'b0);
        @(negedge clk);

        // Round trip: forward instance -> relay -> inverse instance.
        fm_ready = 1'b0;
        im_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < RT_N && !abort; i++) begin
                    p_state = {$urandom, $urandom, $urandom, $urandom};
                    exp_q.push_back(p_state);
                    for (int k = 0; k < 16 && !abort; k++) begin
                        while ($urandom_range(0, 3) == 0) @(negedge clk);
                        send_byte(1'b0, p_state[8*k +: 8], k == 15);
                    end
                end
            end
            begin
                for (int i = 0; i < RT_N && !abort; i++) begin
                    g_wait   = 0;
                    fm_ready = ($urandom_range(0, 3) != 0);
                    while (!(fm_valid && fm_ready) && g_wait < BOUND) begin
                        @(negedge clk);
                        g_wait++;
                        fm_ready = ($urandom_range(0, 3) != 0);
                    end
                    if (g_wait >= BOUND) begin
                        check_bit("relay wait timeout", 1'b0, 1'b1);
                        abort = 1'b1;
                    end else begin
                        g_word = fm_data;
                        @(negedge clk);
                        fm_ready = 1'b0;
                        for (int k = 0; k < 16 && !abort; k++) begin
                            while ($urandom_range(0, 3) == 0) @(negedge clk);
                            send_byte(1'b1, g_word[8*k +: 8], k == 15);
                        end
                    end
                end
                fm_ready = 1'b0;
            end
            begin
                for (int i = 0; i < RT_N && !abort; i++) begin
                    c_wait   = 0;
                    im_ready = ($urandom_range(0, 3) != 0);
                    while (!(im_valid && im_ready) && c_wait < BOUND) begin
                        @(negedge clk);
                        c_wait++;
                        im_ready = ($urandom_range(0, 3) != 0);
                    end
                    if (c_wait >= BOUND) begin
                        check_bit("round trip wait timeout", 1'b0, 1'b1);
                        abort = 1'b1;
                    end else begin
                        if (exp_q.size() == 0) begin
                            check_bit("round trip unexpected output", 1'b1, 1'b0);
                        end else begin
                            c_exp = exp_q.pop_front();
                            check("round trip", im_data, c_exp);
                        end
                        @(negedge clk);
                    end
                end
                im_ready = 1'b0;
            end
        join
        check("round trip leftover", 128'(exp_q.size()), 128'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
